// File: rtl/syndrome_frame_sequencer.sv
// RS(15,11) decoder front end: ping-pong codeword buffer that bursts each full frame
// contiguously into the four syndrome cells and holds S1..S4 plus the codeword for the corrector.
module syndrome_frame_sequencer #(
    parameter int NSYM = 15,
    parameter int W    = 4,
    parameter int NSYN = 4
) (
    input  logic         CLK,
    input  logic         RESET_GLOBAL,
    input  logic         IN_VALID,
    input  logic [W-1:0] IN_SYMBOL,
    output logic         IN_READY,
    output logic [W-1:0] SYN_SERIAL,
    output logic [W-1:0] SYN_CONTROL,
    input  logic [W-1:0] SYN_IN1,
    input  logic [W-1:0] SYN_IN2,
    input  logic [W-1:0] SYN_IN3,
    input  logic [W-1:0] SYN_IN4,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] S1,
    output logic [W-1:0] S2,
    output logic [W-1:0] S3,
    output logic [W-1:0] S4,
    output logic         ERR_FLAG,
    input  logic [3:0]   CW_RD_ADDR,
    output logic [W-1:0] CW_RD_DATA
);
    localparam int CW = $clog2(NSYM);
    localparam logic [CW-1:0] LAST = CW'(NSYM - 1);

    typedef enum logic [1:0] {PH_IDLE, PH_BURST, PH_HELD} phase_t;

    phase_t        phase_q, phase_d;
    logic          fill_sel_q, fill_sel_d;
    logic          full_q, full_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] b_q, b_d;
    logic [W-1:0]  syn_q [NSYN];
    logic [W-1:0]  syn_d [NSYN];
    logic          err_q, err_d;
    logic [W-1:0]  syn_in_w [NSYN];
    logic [W-1:0]  mem_q [2][NSYM];

    logic          act_sel;
    logic          in_fire, fill_done, rel, start;
    logic [CW-1:0] wr_idx, rd_idx;

    assign syn_in_w[0] = SYN_IN1;
    assign syn_in_w[1] = SYN_IN2;
    assign syn_in_w[2] = SYN_IN3;
    assign syn_in_w[3] = SYN_IN4;

    // The burst/held bank is always the one not selected for filling.
    assign act_sel   = ~fill_sel_q;
    assign IN_READY  = RESET_GLOBAL & ~full_q;
    assign in_fire   = IN_VALID & IN_READY;
    assign fill_done = in_fire && (cnt_q == LAST);
    assign rel       = (phase_q == PH_HELD) && OUT_READY;
    assign start     = (full_q | fill_done) && ((phase_q == PH_IDLE) || rel);
    assign wr_idx    = LAST - cnt_q;
    assign rd_idx    = LAST - b_q;

    always_comb begin
        phase_d    = phase_q;
        fill_sel_d = fill_sel_q;
        full_d     = full_q;
        cnt_d      = cnt_q;
        b_d        = b_q;
        err_d      = err_q;
        for (int k = 0; k < NSYN; k++) syn_d[k] = syn_q[k];

        if (in_fire) cnt_d = cnt_q + 1'b1;
        if (fill_done) begin
            cnt_d  = '0;
            full_d = 1'b1;
        end

        if (start) begin
            full_d     = 1'b0;
            fill_sel_d = ~fill_sel_q;
            phase_d    = PH_BURST;
            b_d        = '0;
        end else begin
            case (phase_q)
                PH_BURST: begin
                    if (b_q == LAST) begin
                        for (int k = 0; k < NSYN; k++) syn_d[k] = syn_in_w[k];
                        err_d   = |{SYN_IN1, SYN_IN2, SYN_IN3, SYN_IN4};
                        phase_d = PH_HELD;
                        b_d     = '0;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
                PH_HELD:  if (OUT_READY) phase_d = PH_IDLE;
                default:  phase_d = phase_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_GLOBAL) begin
        if (!RESET_GLOBAL) begin
            phase_q    <= PH_IDLE;
            fill_sel_q <= 1'b0;
            full_q     <= 1'b0;
            cnt_q      <= '0;
            b_q        <= '0;
            err_q      <= 1'b0;
            for (int k = 0; k < NSYN; k++) syn_q[k] <= '0;
        end else begin
            phase_q    <= phase_d;
            fill_sel_q <= fill_sel_d;
            full_q     <= full_d;
            cnt_q      <= cnt_d;
            b_q        <= b_d;
            err_q      <= err_d;
            for (int k = 0; k < NSYN; k++) syn_q[k] <= syn_d[k];
        end
    end

    // Buffer contents survive reset; only the bookkeeping is cleared.
    always_ff @(posedge CLK) begin
        if (in_fire) mem_q[fill_sel_q][wr_idx] <= IN_SYMBOL;
    end

    // Control is zero on b=0 so the cells' leftover state is masked at frame start.
    assign SYN_SERIAL  = (phase_q == PH_BURST) ? mem_q[act_sel][rd_idx] : '0;
    assign SYN_CONTROL = (phase_q == PH_BURST && b_q != '0) ? {W{1'b1}} : '0;
    assign CW_RD_DATA  = (phase_q == PH_HELD && CW_RD_ADDR <= LAST)
                         ? mem_q[act_sel][CW_RD_ADDR[CW-1:0]] : '0;

    assign OUT_VALID = (phase_q == PH_HELD);
    assign S1        = syn_q[0];
    assign S2        = syn_q[1];
    assign S3        = syn_q[2];
    assign S4        = syn_q[3];
    assign ERR_FLAG  = err_q;
endmodule

// File: doc/syndrome_frame_sequencer.md
Name: syndrome_frame_sequencer

Overview:
- Front end of the RS(15,11) decoder over GF(16), p(x)=x^4+x+1. Sits directly upstream of the four syndrome cells (multipliers α^1..α^4).
- Each syndrome cell's register clocks every cycle and has no enable, so a frame must be fed as 15 back-to-back symbols. This block takes a gappy valid/ready symbol stream into a two-bank ping-pong codeword buffer.
- It bursts each full frame contiguously into the cells, driving their shared serial input and CONTROL mask, and captures S1..S4.
- It presents the syndromes plus a read port on the held codeword to the downstream error corrector.

Parameters:
- NSYM, 15, symbols per codeword.
- W, 4, symbol width in bits.
- NSYN, 4, number of syndromes (2t).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_GLOBAL  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  input symbol valid.
- IN_SYMBOL  in  W  received symbol; first symbol of a frame is r14, last is r0.
- IN_READY  out  1  a fill bank is available.
- SYN_SERIAL  out  W  to IN_SERIAL of all four syndrome cells.
- SYN_CONTROL  out  W  to CONTROL of all four cells.
- SYN_IN1..SYN_IN4  in  W each  OUT_SERIAL of cells α^1..α^4 (combinational in the cell).
- OUT_VALID  out  1  syndromes valid.
- OUT_READY  in  1  downstream accepts syndromes and releases the bank.
- S1..S4  out  W each  captured syndromes.
- ERR_FLAG  out  1  OR-reduction of S1..S4 is nonzero.
- CW_RD_ADDR  in  4  symbol index into the held bank, 0 = r0 .. 14 = r14.
- CW_RD_DATA  out  W  combinational read of the held bank.

Behaviour:
- Bank states: each of the 2 banks is in EMPTY, FILLING, BURST or HELD. At most one bank is FILLING and at most one is in BURST or HELD.
- Fill:
  - IN_READY=1 when a bank is FILLING or EMPTY.
  - A transfer occurs on IN_VALID&IN_READY; the symbol is written at index 14-cnt and cnt increments.
  - Gaps in IN_VALID are allowed anywhere in the frame.
  - After the 15th write, the bank goes to BURST if the other bank is EMPTY; otherwise it waits FULL with IN_READY=0.
- Burst:
  - Lasts 15 consecutive cycles b=0..14. SYN_SERIAL is the bank symbol at index 14-b.
  - SYN_CONTROL=4'b0000 on b=0, which masks stale cell state so cells need no reset between frames. It is 4'b1111 on b=1..14.
  - Outside a burst: SYN_SERIAL=0, SYN_CONTROL=0.
  - On b=14, SYN_IN1..4 are registered into S1..S4 and ERR_FLAG is registered. The bank goes to HELD and OUT_VALID=1 from the next cycle.
- Latency: a burst starts the cycle after the 15th input write when a bank is free. OUT_VALID rises 16 cycles after that write.
- Hold and release:
  - S1..S4, ERR_FLAG and the held bank are stable while OUT_VALID=1 and OUT_READY=0.
  - On OUT_VALID&OUT_READY the bank goes to EMPTY and OUT_VALID drops next cycle, unless a FULL bank starts its burst that same cycle (back-to-back).
  - A new fill may proceed throughout burst and hold.
- CW_RD_DATA is undefined (0 is acceptable) when no bank is HELD.
- Simultaneous events: release and completion of the other bank's fill in the same cycle means the full bank enters BURST next cycle. An input write is never lost.
- Reset mid-operation (RESET_GLOBAL=0 at any time):
  - Both banks go EMPTY; cnt and b go to 0.
  - Outputs: IN_READY=0 during reset, then 1 from the first cycle after release.
  - OUT_VALID=0, S1..S4=0, ERR_FLAG=0, SYN_SERIAL=0, SYN_CONTROL=0.
  - A partial frame is discarded. Buffer contents need not be cleared.

Test Plan:
- All-zero frame, IN_VALID continuous, OUT_READY=1 → S1..S4=0x0, ERR_FLAG=0, OUT_VALID pulses once, 16 cycles after the last write.
- Zero frame except r0 (last symbol)=0x1, real cells attached → S1..S4=0x1, ERR_FLAG=1; CW_RD_ADDR=0 reads 0x1.
- Zero frame except r14 (first symbol)=0x1 → S1=0x9, S2=0xD, S3=0xF, S4=0xE; CW_RD_ADDR=14 reads 0x1.
- Random IN_VALID gaps (about 50%) over an r14-error frame → identical syndromes to the previous test. SYN_CONTROL is 0000 exactly once, followed by 14 cycles of 1111, with no gap inside the burst.
- Three frames back-to-back with OUT_READY=0 → IN_READY drops after frame 2 completes. Raising OUT_READY releases frame 1; frame 2 bursts immediately; frame 3 is accepted with no data loss and the syndromes match per frame.
- RESET_GLOBAL asserted at burst cycle b=7, then a clean r0=0x1 frame → no OUT_VALID from the aborted frame, then S1..S4=0x1.
